// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared defaults and pop-length encoding for the instruction prefetch queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prefetch_pkg;

  // Default geometry of the prefetch queue
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_PEEK   = 3;

  // Pop-length encoding, shared with the decoder's instruction-length field
  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_1    = 2'd1;
  localparam logic [1:0] POP_2    = 2'd2;
  localparam logic [1:0] POP_3    = 2'd3;

endpackage

// File: rtl/queue_peek_mux.sv
// queue_peek_mux: selects the PEEK oldest queue entries and zeroes lanes beyond the occupancy.
// Latency: purely combinational.
// Backpressure: none; the output simply follows rd_ptr and count.
module queue_peek_mux #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PEEK   = 3,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DATA_W-1:0]      i_mem [DEPTH],
  input  logic [PTR_W-1:0]       i_rd_ptr,
  input  logic [PTR_W:0]         i_count,
  output logic [PEEK*DATA_W-1:0] o_lanes
);

  for (genvar g = 0; g < PEEK; g++) begin : g_lane
    logic [PTR_W-1:0] w_idx;
    // lane g reads the entry g places after the oldest one, wrapping around the array
    assign w_idx = i_rd_ptr + PTR_W'(g);
    // lanes past the occupancy read as zero rather than stale storage
    assign o_lanes[g*DATA_W +: DATA_W] = (i_count > (PTR_W+1)'(g)) ? i_mem[w_idx] : '0;
  end

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: byte-wide instruction prefetch FIFO; one push per cycle, peek/retire up to PEEK bytes.
// Latency: pushed byte visible on the peek window the cycle after its push (same cycle with QUEUE_BYPASS_EN on an empty queue).
// Backpressure: push is dropped when full (pre-edge count); over-long pops are rejected whole and flagged on queue_pop_err.
// Optional feature macro: QUEUE_BYPASS_EN (empty-queue forwarding of queue_in onto lane 0).
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PEEK   = DEF_PEEK,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int POP_W = $clog2(PEEK + 1)
) (
  input  logic                   clk,
  input  logic                   queue_reset,
  input  logic                   queue_flush,
  input  logic [DATA_W-1:0]      queue_in,
  input  logic                   queue_push,
  input  logic [POP_W-1:0]       queue_pop_len,
  output logic [PEEK*DATA_W-1:0] queue_out,
  output logic [POP_W-1:0]       queue_avail,
  output logic [PTR_W:0]         queue_count,
  output logic                   queue_full,
  output logic                   queue_empty,
  output logic                   queue_pop_err
);

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   PEEK_CNT  = (PTR_W+1)'(PEEK);
  localparam logic [POP_W-1:0] PEEK_POP  = POP_W'(PEEK);

  logic [DATA_W-1:0]      r_mem [DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W:0]         r_count;
  logic                   r_pop_err;

  logic                   w_fwd;
  logic                   w_fwd_take;
  logic                   w_push_ok;
  logic                   w_pop_ok;
  logic [POP_W-1:0]       w_avail;
  logic [PTR_W:0]         w_pop_amt;
  logic [PTR_W:0]         w_push_amt;
  logic [PEEK*DATA_W-1:0] w_lanes;

  // Forwarding is only possible into an empty queue, and a flush kills it
`ifdef QUEUE_BYPASS_EN
  assign w_fwd = (r_count == '0) && queue_push && !queue_flush;
`else
  assign w_fwd = 1'b0;
`endif

  // A forwarded byte retired in the same cycle never touches storage
  assign w_fwd_take = w_fwd && (queue_pop_len == POP_W'(POP_1));

  assign w_avail    = w_fwd ? POP_W'(1) :
                      (r_count >= PEEK_CNT) ? PEEK_POP : r_count[POP_W-1:0];
  assign w_pop_ok   = (queue_pop_len <= w_avail);
  assign w_push_ok  = queue_push && (r_count != DEPTH_CNT) && !w_fwd_take;
  assign w_push_amt = {{PTR_W{1'b0}}, w_push_ok};

  // Retire amount: all or nothing, and nothing when the forwarded byte is consumed
  always_comb begin
    w_pop_amt = '0;
    if (w_pop_ok && !w_fwd_take) w_pop_amt[POP_W-1:0] = queue_pop_len;
  end

  queue_peek_mux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PEEK   (PEEK),
    .PTR_W  (PTR_W)
  ) u_peek (
    .i_mem    (r_mem),
    .i_rd_ptr (r_rd_ptr),
    .i_count  (r_count),
    .o_lanes  (w_lanes)
  );

  // Peek window, with lane 0 overridden by the forwarded byte when bypassing
  always_comb begin
    queue_out = w_lanes;
    if (w_fwd) queue_out[DATA_W-1:0] = queue_in;
  end

  // Storage is not reset; writes are suppressed by reset and flush
  always_ff @(posedge clk) begin
    if (!queue_reset && !queue_flush && w_push_ok) r_mem[r_wr_ptr] <= queue_in;
  end

  // Pointer, occupancy and error-flag update; reset beats flush beats push/pop
  always_ff @(posedge clk) begin
    if (queue_reset || queue_flush) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_pop_err <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr  <= r_rd_ptr + w_pop_amt[PTR_W-1:0];
      r_count   <= r_count + w_push_amt - w_pop_amt;
      r_pop_err <= !w_pop_ok;
    end
  end

  assign queue_avail   = w_avail;
  assign queue_count   = r_count;
  assign queue_full    = (r_count == DEPTH_CNT);
  assign queue_empty   = (r_count == '0);
  assign queue_pop_err = r_pop_err;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed plus randomized stimulus for prefetch_queue against a queue-based model.
module tb_prefetch_queue;
  import prefetch_pkg::*;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int PK = 3;
`ifdef QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           queue_reset = 1'b1;
  logic           queue_flush = 1'b0;
  logic [DW-1:0]  queue_in = '0;
  logic           queue_push = 1'b0;
  logic [1:0]     queue_pop_len = '0;
  logic [PK*DW-1:0] queue_out;
  logic [1:0]     queue_avail;
  logic [4:0]     queue_count;
  logic           queue_full;
  logic           queue_empty;
  logic           queue_pop_err;

  always #5 clk = ~clk;

  prefetch_queue #(.DATA_W(DW), .DEPTH(DP), .PEEK(PK)) dut (
    .clk           (clk),
    .queue_reset   (queue_reset),
    .queue_flush   (queue_flush),
    .queue_in      (queue_in),
    .queue_push    (queue_push),
    .queue_pop_len (queue_pop_len),
    .queue_out     (queue_out),
    .queue_avail   (queue_avail),
    .queue_count   (queue_count),
    .queue_full    (queue_full),
    .queue_empty   (queue_empty),
    .queue_pop_err (queue_pop_err)
  );

  typedef struct {
    int             count;
    int             avail;
    logic [PK*DW-1:0] lanes;
    bit             full;
    bit             empty;
    bit             err;
    string          tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  bit         m_err   = 1'b0;
  bit         m_valid = 1'b0;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // One clock of stimulus: drive inputs, record what the outputs must show now, advance the model.
  task automatic cycle(input bit rst, input bit fl, input bit ps, input logic [7:0] d,
                       input int pl, input string tag);
    exp_t e;
    int   sz;
    int   av;
    bit   fwd;
    bit   pop_ok;
    bit   full_pre;
    @(negedge clk);
    queue_reset   = rst;
    queue_flush   = fl;
    queue_push    = ps;
    queue_in      = d;
    queue_pop_len = pl[1:0];
    sz  = mq.size();
    fwd = BYP && (sz == 0) && ps && !fl;
    av  = fwd ? 1 : ((sz < PK) ? sz : PK);
    if (m_valid) begin
      e.lanes = '0;
      for (int i = 0; i < PK; i++) if (i < sz) e.lanes[i*DW +: DW] = mq[i];
      if (fwd) e.lanes[DW-1:0] = d;
      e.count = sz;
      e.avail = av;
      e.full  = (sz == DP);
      e.empty = (sz == 0);
      e.err   = m_err;
      e.tag   = tag;
      exp_q.push_back(e);
    end
    if (rst) begin
      mq.delete();
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (fl) begin
        mq.delete();
        m_err = 1'b0;
      end else begin
        pop_ok = (pl <= av);
        m_err  = !pop_ok;
        if (!(fwd && pl == 1)) begin
          full_pre = (sz == DP);
          if (pop_ok) repeat (pl) void'(mq.pop_front());
          if (ps && !full_pre) mq.push_back(d);
        end
      end
    end
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, tag);
  endtask

  task automatic push(input logic [7:0] d, input string tag);
    cycle(1'b0, 1'b0, 1'b1, d, 0, tag);
  endtask

  task automatic pop(input int n, input string tag);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, n, tag);
  endtask

  // Monitor: every cycle the DUT presents a set of outputs; compare against the oldest expectation.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, "_count"}, queue_count,   e.count);
        check({e.tag, "_avail"}, queue_avail,   e.avail);
        check({e.tag, "_out"},   queue_out,     e.lanes);
        check({e.tag, "_full"},  queue_full,    e.full);
        check({e.tag, "_empty"}, queue_empty,   e.empty);
        check({e.tag, "_err"},   queue_pop_err, e.err);
      end
    end
  end

  initial begin : drv
    int pl;
    // reset
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 0, "rst0");
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 0, "rst1");
    idle("reset_state");
    // three pushes, then retire two
    push(8'hA9, "t1_push0");
    push(8'h01, "t1_push1");
    push(8'h8D, "t1_push2");
    idle("t1_three");
    pop(2, "t1_pop2");
    idle("t1_after_pop");
    // move pointers to 14, then fill, overfill with pop, drain across wrap
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 0, "t2_flush");
    for (int i = 0; i < 14; i++) push(8'(8'h10 + i), "t2_pre");
    pop(3, "t2_pre_pop"); pop(3, "t2_pre_pop"); pop(3, "t2_pre_pop");
    pop(3, "t2_pre_pop"); pop(2, "t2_pre_pop");
    for (int i = 0; i < 16; i++) push(8'(8'hC0 + i), "t2_fill");
    cycle(1'b0, 1'b0, 1'b1, 8'hEE, 1, "t2_full_push");
    for (int i = 0; i < 5; i++) pop(3, "t2_drain");
    idle("t2_empty");
    // illegal pop
    push(8'h3A, "t3_push");
    pop(3, "t3_bad_pop");
    idle("t3_err");
    idle("t3_err_clear");
    // flush with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i), "t4_fill");
    cycle(1'b0, 1'b1, 1'b1, 8'h55, 2, "t4_flush");
    idle("t4_after_flush");
    push(8'h77, "t4_push");
    idle("t4_readback");
    // steady stream at count 2, then reset mid-stream
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 0, "t5_flush");
    push(8'h90, "t5_push"); push(8'h91, "t5_push");
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1, "t5_stream");
    cycle(1'b1, 1'b0, 1'b1, 8'h5A, 1, "t5_reset");
    idle("t5_after_reset");
    // empty-queue push with same-cycle pop
    cycle(1'b0, 1'b0, 1'b1, 8'h4C, 1, "t6_bypass");
    idle("t6_after");
    idle("t6_after2");
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pl = $urandom_range(0, 3);
      cycle(($urandom % 300) == 0, ($urandom % 60) == 0,
            (i < 1500) ? (($urandom % 10) != 0) : (($urandom % 10) < 4),
            8'($urandom), pl, "rand");
    end
    idle("final");
    repeat (3) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Parametrised instruction-byte prefetch FIFO between inst_fetch and prime_decoder; successor to queue_rotation.
- Memory fetch pushes one byte per cycle. The decoder peeks at the next PEEK bytes and retires 0..PEEK bytes per cycle, matching inst_len.
- queue_flush discards all contents on a taken branch or interrupt.
- Occupancy, full and empty flags are exact.

Parameters:
- DATA_W, 8, width of one queue entry (bits).
- DEPTH, 16, number of entries; power of two, at least 4.
- PEEK, 3, number of peek lanes, which is also the maximum pop per cycle; 1 <= PEEK <= DEPTH.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.
- POP_W, $clog2(PEEK+1), width of the pop-length field; derived.

Ports:
- clk  in  1  rising-edge clock.
- queue_reset  in  1  synchronous active-high reset.
- queue_flush  in  1  discard all entries.
- queue_in  in  DATA_W  byte to push.
- queue_push  in  1  push request.
- queue_pop_len  in  POP_W  bytes to retire this cycle (0..PEEK).
- queue_out  out  PEEK*DATA_W  peek window; lane 0 (oldest entry) in the LSBs.
- queue_avail  out  POP_W  min(count, PEEK); number of valid lanes.
- queue_count  out  PTR_W+1  occupancy, 0..DEPTH.
- queue_full  out  1  count == DEPTH.
- queue_empty  out  1  count == 0.
- queue_pop_err  out  1  registered; pulses one cycle after an illegal pop.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, queue_reset). No asynchronous logic.
- State: storage array, rd_ptr, wr_ptr (PTR_W bits each, wrapping modulo DEPTH), count (PTR_W+1 bits).
- Reset values: rd_ptr=0, wr_ptr=0, count=0, queue_pop_err=0. Storage contents are not reset.
- Output values at reset: queue_empty=1, queue_full=0, queue_avail=0, queue_out all zero.
- Push acceptance: push_ok = queue_push && (count < DEPTH).
  - Fullness is judged on the pre-edge count. A push while full is dropped, even if a pop happens in the same cycle.
  - An accepted push writes queue_in at wr_ptr; wr_ptr advances by 1 with wrap.
- Pop acceptance: pop_ok = (queue_pop_len <= queue_avail).
  - If pop_ok, rd_ptr advances by queue_pop_len with wrap.
  - If not, there is no pop at all (no partial retire), and queue_pop_err=1 on the next cycle.
  - queue_pop_err is 0 in every other cycle.
- Count update: count_next = count + push_ok - (pop_ok ? queue_pop_len : 0). Push and pop in the same cycle are legal.
- Peek (combinational from registered state):
  - Lane i = storage[(rd_ptr+i) mod DEPTH] when i < count; otherwise lane i = 0.
  - A pushed byte becomes visible in the cycle after its push.
- Flush: queue_flush=1 sets rd_ptr=wr_ptr=0 and count=0 on the edge.
  - A push or pop presented in the same cycle is ignored.
  - queue_pop_err is not raised during a flush cycle.
- Priority: queue_reset > queue_flush > push/pop.
- Reset mid-operation: all state is lost at the edge; the first output after reset is empty.
- Flags are decoded from count; there is no separate full flop.

Optional Feature:
- Macro QUEUE_BYPASS_EN.
- Defined: when count==0 and queue_push=1, the incoming byte is forwarded combinationally.
  - Lane 0 = queue_in and queue_avail=1 in the same cycle.
  - queue_pop_len=1 consumes the byte without writing it: pointers and count stay unchanged.
  - queue_pop_len=0 stores the byte normally.
  - queue_flush still blocks both the forward and the store.
- Undefined: no forwarding. Empty means queue_avail=0, and any nonzero pop_len is an error.

Decomposition:
- Package prefetch_pkg holds:
  - default DATA_W, DEPTH and PEEK localparams;
  - the pop-length encoding constants POP_NONE, POP_1, POP_2, POP_3, shared with addr_mode's inst_len.
- One natural sub-module: queue_peek_mux, a combinational lane selector with masking. Inputs are the storage array, rd_ptr and count; the output is queue_out.

Test Plan:
- Reset, then push 0xA9, 0x01, 0x8D on consecutive cycles -> count=3, avail=3, queue_out={0x8D,0x01,0xA9}; pop_len=2 -> next cycle count=1, lane0=0x8D, lanes1-2=0.
- Push 16 bytes -> full=1; a 17th push with pop_len=1 -> count=15 and the byte is not stored. Then pop until empty across the rd_ptr wrap (pushes started at wr_ptr=14) -> byte order is preserved.
- count=1, pop_len=3 -> no pointer change, count stays 1, queue_pop_err=1 for exactly one cycle.
- count=9, with queue_flush, push=1 and pop_len=2 in the same cycle -> count=0, empty=1, pop_err=0; the next push is read back at lane 0.
- Steady state with push=1 and pop_len=1 every cycle at count=2 -> count stays 2 and the data stream is in order. Assert queue_reset mid-stream -> all outputs return to reset values on the next cycle.
- With QUEUE_BYPASS_EN, count=0, push 0x4C and pop_len=1 in the same cycle -> lane0=0x4C the same cycle, count stays 0. Without the macro, the same stimulus -> pop_err=1, count=1.
